// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: power-up / re-lock sequencer for an rPLL feeding a Micro80 core.
//
// Brings the PLL out of reset, waits for a synchronized LOCK, requires LOCK to
// stay stable for a while, then releases the core reset and produces a divided
// one-cycle CPU clock enable. Lock loss while running restarts the sequence; a
// bounded number of failed lock attempts latches a fault.
//
// Ports:
//   clk          free-running 40 MHz board clock (not the PLL output)
//   rst          synchronous active-high reset
//   pll_lock_i   rPLL LOCK, asynchronous to clk
//   soft_rst_req single-cycle system-reset request, honoured only in RUN
//   pll_reset    rPLL RESET pin drive (registered)
//   sys_rst      core reset, low only while running (registered)
//   cpu_ce       one-cycle CPU clock enable, period CE_DIV (registered)
//   state        current FSM state encoding
//   retry_cnt    failed lock attempts, saturating at 15
//   fault        lock-failure latch, cleared only by rst
module pll_seq_ctrl #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 64,
    parameter int MAX_RETRY      = 8,
    parameter int CE_DIV         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock_i,
    input  logic       soft_rst_req,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       cpu_ce,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic       fault
);

    localparam int MAX_A  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // The counter only ever reaches (parameter - 1), so clog2 of the largest
    // parameter is wide enough.
    localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int CE_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CE_W-1:0]  CE_LAST     = CE_W'(CE_DIV - 1);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        HOLD      = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d, retry_inc;
    logic [CE_W-1:0]  div_q, div_d;
    logic             lock_q1, lock_s;
    logic             ce_run;

    // Two-flop synchronizer for the asynchronous LOCK input.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_q1 <= pll_lock_i;
            lock_s  <= lock_q1;
        end
    end

    assign retry_inc = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;

    // Next-state logic. Lock loss is tested before any other exit so it wins
    // over a coincident soft reset request or a counter expiry.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (int'(retry_inc) == MAX_RETRY) ? FAULT : PLL_RST;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = 4'd0;
                end
            end
            RUN: begin
                if (!lock_s)          state_d = PLL_RST;
                else if (soft_rst_req) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s)               state_d = PLL_RST;
                else if (cnt_q == HOLD_LAST) state_d = RUN;
            end
            FAULT:   state_d = FAULT;
            default: state_d = PLL_RST;
        endcase
    end

    // Shared timer restarts from zero whenever the state changes.
    assign cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    // The divider only advances across consecutive RUN cycles; any other state
    // (or the edge leaving RUN) forces it back to zero. cpu_ce is registered off
    // the terminal count, so the first pulse lands CE_DIV cycles after RUN
    // entry and can never coincide with sys_rst.
    assign ce_run = (state_q == RUN) && (state_d == RUN);
    assign div_d  = !ce_run ? '0 : (div_q == CE_LAST) ? '0 : div_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            retry_q   <= 4'd0;
            div_q     <= '0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            cpu_ce    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            div_q     <= div_d;
            // Outputs decode the next state so they line up with state_q.
            pll_reset <= (state_d == PLL_RST);
            sys_rst   <= (state_d != RUN);
            cpu_ce    <= ce_run && (div_q == CE_LAST);
            fault     <= (state_d == FAULT);
        end
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl with shortened timing parameters.
module tb_pll_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock_i = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       pll_reset, sys_rst, cpu_ce, fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    int errs   = 0;
    int checks = 0;

    pll_seq_ctrl #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (5),
        .MAX_RETRY     (3),
        .CE_DIV        (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock_i  (pll_lock_i),
        .soft_rst_req(soft_rst_req),
        .pll_reset   (pll_reset),
        .sys_rst     (sys_rst),
        .cpu_ce      (cpu_ce),
        .state       (state),
        .retry_cnt   (retry_cnt),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 ns after the last reset edge with rst just released.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, output int n);
        n = 0;
        while (state != s && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"},     32'(state),     32'd0);
        chk({tag, ".pll_reset"}, 32'(pll_reset), 32'd1);
        chk({tag, ".sys_rst"},   32'(sys_rst),   32'd1);
        chk({tag, ".cpu_ce"},    32'(cpu_ce),    32'd0);
        chk({tag, ".retry"},     32'(retry_cnt), 32'd0);
        chk({tag, ".fault"},     32'(fault),     32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, bad, ff;
        int rise[$];
        logic prev;

        // Reset state and normal start-up.
        tick();
        tick();
        chk_reset_vals("rst0");
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_reset) hi++;
            tick();
        end
        chk("startup.pll_reset_cycles", 32'(hi), 32'd4);
        chk("startup.wait_lock", 32'(state), 32'd1);
        pll_lock_i = 1'b1;
        n = 0;
        while (sys_rst && n < 40) begin
            tick();
            n++;
        end
        chk("startup.sys_rst_fall", 32'(n), 32'd11);
        chk("startup.run", 32'(state), 32'd3);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("startup.ce%0d", k), 32'(cpu_ce), 32'((k % 4) == 0));
        end

        // Soft reset from RUN.
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        chk("soft.hold", 32'(state), 32'd4);
        n = 0;
        bad = 0;
        while (sys_rst && n < 20) begin
            if (cpu_ce) bad++;
            n++;
            tick();
        end
        chk("soft.sys_rst_width", 32'(n), 32'd5);
        chk("soft.ce_suppressed", 32'(bad), 32'd0);
        chk("soft.back_run", 32'(state), 32'd3);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("soft.ce%0d", k), 32'(cpu_ce), 32'(k == 4));
        end

        // Lock loss and soft reset seen in the same cycle: lock loss wins.
        pll_lock_i = 1'b0;
        tick();
        tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        chk("simul.state", 32'(state), 32'd0);
        chk("simul.pll_reset", 32'(pll_reset), 32'd1);
        chk("simul.sys_rst", 32'(sys_rst), 32'd1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (state == 3'd4) bad++;
            tick();
        end
        chk("simul.no_hold", 32'(bad), 32'd0);

        // Reset in the middle of RUN.
        pll_lock_i = 1'b1;
        wait_state(3'd3, 80, n);
        chk("rerun.state", 32'(state), 32'd3);
        rst = 1'b1;
        tick();
        chk_reset_vals("rst_run");

        // One-cycle lock glitch in STABLE after 5 stable cycles.
        pll_lock_i = 1'b0;
        do_reset();
        wait_state(3'd1, 20, n);
        pll_lock_i = 1'b1;
        wait_state(3'd2, 20, n);
        chk("glitch.stable", 32'(state), 32'd2);
        for (int i = 0; i < 4; i++) tick();
        pll_lock_i = 1'b0;
        tick();
        pll_lock_i = 1'b1;
        tick();
        tick();
        chk("glitch.wait_lock", 32'(state), 32'd1);
        chk("glitch.retry", 32'(retry_cnt), 32'd0);
        chk("glitch.sys_rst", 32'(sys_rst), 32'd1);
        n = 0;
        while (state != 3'd3 && n < 40) begin
            tick();
            n++;
        end
        chk("glitch.restart_len", 32'(n), 32'd9);

        // Lock never arrives: three attempts, then FAULT.
        pll_lock_i = 1'b0;
        do_reset();
        prev = 1'b0;
        hi = 0;
        ff = -1;
        for (int c = 0; c < 120; c++) begin
            if (pll_reset && !prev) rise.push_back(c);
            prev = pll_reset;
            if (pll_reset) hi++;
            if (fault && ff < 0) ff = c;
            tick();
        end
        chk("nolock.pulses", 32'(rise.size()), 32'd3);
        if (rise.size() == 3) begin
            chk("nolock.rise1", 32'(rise[1]), 32'd36);
            chk("nolock.rise2", 32'(rise[2]), 32'd72);
        end
        chk("nolock.hi_cycles", 32'(hi), 32'd12);
        chk("nolock.fault_at", 32'(ff), 32'd108);
        chk("nolock.state", 32'(state), 32'd5);
        chk("nolock.fault", 32'(fault), 32'd1);
        chk("nolock.retry", 32'(retry_cnt), 32'd3);
        chk("nolock.sys_rst", 32'(sys_rst), 32'd1);
        chk("nolock.pll_reset", 32'(pll_reset), 32'd0);

        // Reset while in FAULT.
        rst = 1'b1;
        tick();
        chk_reset_vals("rst_fault");
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
